// File: rtl/fft_out_reorder_pkg.sv
// Shared constants, sample payload and read-FSM encoding for the FFT output reorder buffer.
package fft_out_reorder_pkg;

    localparam int unsigned FFT_N     = 32;
    localparam int unsigned FFT_LOG2N = 5;
    localparam int unsigned FFT_WIDTH = 18;

    // One complex sample as stored in a reorder bank
    typedef struct packed {
        logic [FFT_WIDTH-1:0] re;
        logic [FFT_WIDTH-1:0] im;
    } sample_t;

    typedef enum logic {
        RD_IDLE = 1'b0,
        RD_READ = 1'b1
    } rd_state_e;

    // Mirror the index bits: MSB becomes LSB
    function automatic logic [FFT_LOG2N-1:0] bitrev(input logic [FFT_LOG2N-1:0] idx);
        logic [FFT_LOG2N-1:0] r;
        r = '0;
        for (int b = 0; b < FFT_LOG2N; b++) begin
            r[b] = idx[FFT_LOG2N-1-b];
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_out_reorder_if.sv
// Sample stream bundle for the reorder buffer: bit-reversed input side and natural-order output side.
// REORDER_OVF_FLAG_EN adds the sticky overflow flag.
interface fft_out_reorder_if;
    import fft_out_reorder_pkg::*;

    logic                 in_valid;
    logic [FFT_WIDTH-1:0] in_r;
    logic [FFT_WIDTH-1:0] in_i;
    logic                 out_valid;
    logic [FFT_WIDTH-1:0] out_r;
    logic [FFT_WIDTH-1:0] out_i;
    logic [FFT_LOG2N-1:0] out_idx;
    logic                 out_last;
`ifdef REORDER_OVF_FLAG_EN
    logic                 ovf;

    modport master (output in_valid, in_r, in_i,
                    input  out_valid, out_r, out_i, out_idx, out_last, ovf);
    modport slave  (input  in_valid, in_r, in_i,
                    output out_valid, out_r, out_i, out_idx, out_last, ovf);
`else
    modport master (output in_valid, in_r, in_i,
                    input  out_valid, out_r, out_i, out_idx, out_last);
    modport slave  (input  in_valid, in_r, in_i,
                    output out_valid, out_r, out_i, out_idx, out_last);
`endif

endinterface

// File: rtl/fft_out_reorder_bank.sv
// One reorder bank: N-entry 1W/1R synchronous RAM with registered read data.
module fft_out_reorder_bank
    import fft_out_reorder_pkg::*;
(
    input  logic                 clk,
    input  logic                 we,
    input  logic [FFT_LOG2N-1:0] waddr,
    input  sample_t              wdata,
    input  logic                 re,
    input  logic [FFT_LOG2N-1:0] raddr,
    output sample_t              rdata
);

    sample_t mem [FFT_N];

    // Storage has no reset; only read data qualified by the reader is ever used
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/fft_out_reorder.sv
// Ping-pong reorder buffer: takes bit-reversed FFT frames and re-emits them in natural bin order.
// Optional REORDER_OVF_FLAG_EN: sticky overflow flag, samples arriving into a full bank are dropped.
module fft_out_reorder
    import fft_out_reorder_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    fft_out_reorder_if.slave  bus
);

    localparam int unsigned L = FFT_LOG2N;

    logic [L-1:0] wr_idx;
    logic         wr_bank;
    logic [1:0]   bank_full;
    logic         wr_en_c;
    logic         wr_done_c;
    logic [1:0]   set_vec_c;
    logic [1:0]   clr_vec_c;

    rd_state_e    state, state_nxt;
    logic [L-1:0] rd_idx, rd_idx_nxt;
    logic         rd_bank, rd_bank_nxt;
    logic         oldest_c;
    logic         issue_c;
    logic         issue_bank_c;
    logic [L-1:0] issue_idx_c;
    logic         clr_c;

    logic         v1;
    logic         bank1;
    logic [L-1:0] idx1;

    sample_t      wdata;
    sample_t      rdata0, rdata1, rd_mux;

    logic         out_valid_q;
    logic [FFT_WIDTH-1:0] out_r_q, out_i_q;
    logic [L-1:0] out_idx_q;
    logic         out_last_q;

`ifdef REORDER_OVF_FLAG_EN
    logic ovf_q;
    assign wr_en_c = bus.in_valid && !bank_full[wr_bank];

    // Sticky overflow: a sample showed up while its target bank was still full
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (bus.in_valid && bank_full[wr_bank]) begin
            ovf_q <= 1'b1;
        end
    end

    assign bus.ovf = ovf_q;
`else
    assign wr_en_c = bus.in_valid;
`endif

    assign wr_done_c = wr_en_c && (wr_idx == L'(FFT_N - 1));
    assign wdata     = '{re: bus.in_r, im: bus.in_i};
    assign set_vec_c = wr_done_c ? (wr_bank ? 2'b10 : 2'b01) : 2'b00;
    assign clr_vec_c = clr_c     ? (rd_bank ? 2'b10 : 2'b01) : 2'b00;
    // With both banks full the one the writer points at was filled first
    assign oldest_c  = (&bank_full) ? wr_bank : bank_full[1];

    // Write pointer and bank toggle at frame end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_idx  <= '0;
            wr_bank <= 1'b0;
        end else if (wr_en_c) begin
            wr_idx <= wr_done_c ? '0 : wr_idx + L'(1);
            if (wr_done_c) begin
                wr_bank <= ~wr_bank;
            end
        end
    end

    // Bank occupancy: writer sets, reader clears; never the same bank in one cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank_full <= 2'b00;
        end else begin
            bank_full <= (bank_full & ~clr_vec_c) | set_vec_c;
        end
    end

    // Reader state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= RD_IDLE;
            rd_idx  <= '0;
            rd_bank <= 1'b0;
        end else begin
            state   <= state_nxt;
            rd_idx  <= rd_idx_nxt;
            rd_bank <= rd_bank_nxt;
        end
    end

    // Reader next state; bin 0 is issued in the IDLE cycle that sees a full bank
    always_comb begin
        state_nxt    = state;
        rd_idx_nxt   = rd_idx;
        rd_bank_nxt  = rd_bank;
        issue_c      = 1'b0;
        issue_bank_c = rd_bank;
        issue_idx_c  = rd_idx;
        clr_c        = 1'b0;
        case (state)
            RD_IDLE: begin
                if (|bank_full) begin
                    issue_c      = 1'b1;
                    issue_bank_c = oldest_c;
                    issue_idx_c  = '0;
                    rd_bank_nxt  = oldest_c;
                    rd_idx_nxt   = L'(1);
                    state_nxt    = RD_READ;
                end
            end
            RD_READ: begin
                issue_c = 1'b1;
                if (rd_idx == L'(FFT_N - 1)) begin
                    clr_c      = 1'b1;
                    rd_idx_nxt = '0;
                    if (bank_full[~rd_bank]) begin
                        rd_bank_nxt = ~rd_bank;
                    end else begin
                        state_nxt = RD_IDLE;
                    end
                end else begin
                    rd_idx_nxt = rd_idx + L'(1);
                end
            end
            default: state_nxt = RD_IDLE;
        endcase
    end

    fft_out_reorder_bank u_bank0 (
        .clk   (clk),
        .we    (wr_en_c && !wr_bank),
        .waddr (bitrev(wr_idx)),
        .wdata (wdata),
        .re    (issue_c && !issue_bank_c),
        .raddr (issue_idx_c),
        .rdata (rdata0)
    );

    fft_out_reorder_bank u_bank1 (
        .clk   (clk),
        .we    (wr_en_c && wr_bank),
        .waddr (bitrev(wr_idx)),
        .wdata (wdata),
        .re    (issue_c && issue_bank_c),
        .raddr (issue_idx_c),
        .rdata (rdata1)
    );

    assign rd_mux = bank1 ? rdata1 : rdata0;

    // Track the read issued last cycle alongside the RAM access
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1    <= 1'b0;
            bank1 <= 1'b0;
            idx1  <= '0;
        end else begin
            v1    <= issue_c;
            bank1 <= issue_bank_c;
            idx1  <= issue_idx_c;
        end
    end

    // Output register; fields forced to zero when not valid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_r_q     <= '0;
            out_i_q     <= '0;
            out_idx_q   <= '0;
            out_last_q  <= 1'b0;
        end else begin
            out_valid_q <= v1;
            out_r_q     <= v1 ? rd_mux.re : '0;
            out_i_q     <= v1 ? rd_mux.im : '0;
            out_idx_q   <= v1 ? idx1 : '0;
            out_last_q  <= v1 && (idx1 == L'(FFT_N - 1));
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_r     = out_r_q;
    assign bus.out_i     = out_i_q;
    assign bus.out_idx   = out_idx_q;
    assign bus.out_last  = out_last_q;

endmodule

// File: tb/tb_fft_out_reorder.sv
// Bench for fft_out_reorder: random frames driven in bit-reversed order, natural-order output
// checked against a frame-level model (expected bins queued in natural order).
module tb_fft_out_reorder;
    import fft_out_reorder_pkg::*;

    localparam int N = 32;
    localparam int W = 18;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fft_out_reorder_if intf ();
    fft_out_reorder dut (.clk(clk), .rst_n(rst_n), .bus(intf));

    int vectors = 0;
    int errors  = 0;
    int cyc     = 0;

    int           mon_cyc [$];
    int           mon_idx [$];
    logic [W-1:0] mon_r [$];
    logic [W-1:0] mon_i [$];
    logic         mon_last [$];
    logic [W-1:0] exp_r [$];
    logic [W-1:0] exp_i [$];
    logic [W-1:0] fr_r [N];
    logic [W-1:0] fr_i [N];

    always @(posedge clk) cyc <= cyc + 1;

    // Record every valid output beat with the edge number that produced it
    always @(negedge clk) begin
        if (intf.out_valid === 1'b1) begin
            mon_cyc.push_back(cyc);
            mon_idx.push_back(int'(intf.out_idx));
            mon_r.push_back(intf.out_r);
            mon_i.push_back(intf.out_i);
            mon_last.push_back(intf.out_last);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    // Reference index mirror: build the reversed number one bit at a time
    function automatic int rev5(input int p);
        int r = 0;
        for (int b = 0; b < 5; b++) r = r * 2 + ((p >> b) & 1);
        return r;
    endfunction

    task automatic clear_q();
        mon_cyc.delete(); mon_idx.delete(); mon_r.delete(); mon_i.delete(); mon_last.delete();
        exp_r.delete(); exp_i.delete();
    endtask

    task automatic fill_random();
        for (int k = 0; k < N; k++) begin
            fr_r[k] = W'($urandom);
            fr_i[k] = W'($urandom);
        end
    endtask

    // Send frame fr_* in bit-reversed order; gap idle cycles after each sample
    task automatic drive_frame(input int gap, output int e_edge);
        e_edge = 0;
        for (int p = 0; p < N; p++) begin
            intf.in_valid = 1'b1;
            intf.in_r = fr_r[rev5(p)];
            intf.in_i = fr_i[rev5(p)];
            @(posedge clk); #1;
            if (p == N - 1) e_edge = cyc;
            if (gap > 0) begin
                intf.in_valid = 1'b0;
                repeat (gap) begin @(posedge clk); #1; end
            end
        end
        for (int k = 0; k < N; k++) begin
            exp_r.push_back(fr_r[k]);
            exp_i.push_back(fr_i[k]);
        end
    endtask

    task automatic collect(input int n, input int budget, output bit ok);
        int c = 0;
        while (mon_r.size() < n && c < budget) begin
            @(posedge clk); #1;
            c++;
        end
        ok = (mon_r.size() >= n);
    endtask

    task automatic test_reset();
        intf.in_valid = 1'b0; intf.in_r = '0; intf.in_i = '0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if ({intf.out_valid, intf.out_last, intf.out_idx, intf.out_r, intf.out_i} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got v=%b l=%b idx=%0d r=%h i=%h want all 0",
                     intf.out_valid, intf.out_last, intf.out_idx, intf.out_r, intf.out_i);
        end
`ifdef REORDER_OVF_FLAG_EN
        vectors++;
        if (intf.ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", intf.ovf); end
`endif
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_single_frame();
        int e, first, prev; bit ok;
        clear_q();
        for (int k = 0; k < N; k++) begin fr_r[k] = W'(k); fr_i[k] = W'(-k); end
        drive_frame(0, e);
        intf.in_valid = 1'b0;
        collect(N, 60, ok);
        vectors++;
        if (!ok) begin errors++; $display("FAIL single_count got %0d want %0d", mon_r.size(), N); end
        else begin
            first = mon_cyc[0];
            vectors++;
            if (first !== e + 2) begin errors++; $display("FAIL single_latency got edge %0d want %0d", first, e + 2); end
            prev = first - 1;
            for (int j = 0; j < N; j++) begin
                int c, ix; logic [W-1:0] r, i, er, ei; logic la;
                c = mon_cyc.pop_front(); ix = mon_idx.pop_front(); r = mon_r.pop_front();
                i = mon_i.pop_front(); la = mon_last.pop_front();
                er = exp_r.pop_front(); ei = exp_i.pop_front();
                vectors++;
                if (ix !== j || r !== er || i !== ei || la !== (j == N - 1) || c !== prev + 1) begin
                    errors++;
                    $display("FAIL single_bin[%0d] got idx=%0d r=%h i=%h last=%b edge=%0d want idx=%0d r=%h i=%h last=%b edge=%0d",
                             j, ix, r, i, la, c, j, er, ei, (j == N - 1), prev + 1);
                end
                prev = c;
            end
        end
    endtask

    task automatic test_back_to_back();
        int e, prev; bit ok;
        clear_q();
        for (int f = 0; f < 4; f++) begin
            fill_random();
            drive_frame(0, e);
        end
        intf.in_valid = 1'b0;
        collect(4 * N, 120, ok);
        vectors++;
        if (!ok) begin errors++; $display("FAIL b2b_count got %0d want %0d", mon_r.size(), 4 * N); end
        else begin
            prev = mon_cyc[0] - 1;
            for (int j = 0; j < 4 * N; j++) begin
                int c, ix; logic [W-1:0] r, i, er, ei; logic la;
                c = mon_cyc.pop_front(); ix = mon_idx.pop_front(); r = mon_r.pop_front();
                i = mon_i.pop_front(); la = mon_last.pop_front();
                er = exp_r.pop_front(); ei = exp_i.pop_front();
                vectors++;
                if (ix !== j % N || r !== er || i !== ei || la !== (j % N == N - 1) || c !== prev + 1) begin
                    errors++;
                    $display("FAIL b2b_beat[%0d] got idx=%0d r=%h i=%h last=%b edge=%0d want idx=%0d r=%h i=%h last=%b edge=%0d",
                             j, ix, r, i, la, c, j % N, er, ei, (j % N == N - 1), prev + 1);
                end
                prev = c;
            end
        end
    endtask

    task automatic test_gapped();
        int e, prev; bit ok;
        clear_q();
        for (int f = 0; f < 2; f++) begin
            fill_random();
            drive_frame(2, e);
        end
        intf.in_valid = 1'b0;
        collect(2 * N, 80, ok);
        vectors++;
        if (!ok) begin errors++; $display("FAIL gap_count got %0d want %0d", mon_r.size(), 2 * N); end
        else begin
            prev = 0;
            for (int j = 0; j < 2 * N; j++) begin
                int c, ix; logic [W-1:0] r, i, er, ei; logic la; bit gap_bad;
                c = mon_cyc.pop_front(); ix = mon_idx.pop_front(); r = mon_r.pop_front();
                i = mon_i.pop_front(); la = mon_last.pop_front();
                er = exp_r.pop_front(); ei = exp_i.pop_front();
                gap_bad = (j % N != 0) && (c != prev + 1);
                vectors++;
                if (ix !== j % N || r !== er || i !== ei || la !== (j % N == N - 1) || gap_bad) begin
                    errors++;
                    $display("FAIL gap_beat[%0d] got idx=%0d r=%h i=%h last=%b edge=%0d want idx=%0d r=%h i=%h last=%b contiguous",
                             j, ix, r, i, la, c, j % N, er, ei, (j % N == N - 1));
                end
                prev = c;
            end
        end
    endtask

    task automatic test_reset_mid();
        int e; bit ok;
        clear_q();
        fill_random();
        drive_frame(0, e);
        fill_random();
        for (int p = 0; p < 17; p++) begin
            intf.in_valid = 1'b1;
            intf.in_r = fr_r[rev5(p)];
            intf.in_i = fr_i[rev5(p)];
            @(posedge clk); #1;
        end
        intf.in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({intf.out_valid, intf.out_last, intf.out_idx, intf.out_r, intf.out_i} !== '0) begin
            errors++;
            $display("FAIL midreset_outputs got v=%b l=%b idx=%0d r=%h i=%h want all 0",
                     intf.out_valid, intf.out_last, intf.out_idx, intf.out_r, intf.out_i);
        end
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        clear_q();
        fill_random();
        drive_frame(0, e);
        intf.in_valid = 1'b0;
        collect(N, 60, ok);
        repeat (40) @(posedge clk);
        #1;
        vectors++;
        if (mon_r.size() !== N) begin errors++; $display("FAIL midreset_count got %0d want %0d", mon_r.size(), N); end
        else begin
            for (int j = 0; j < N; j++) begin
                int ix; logic [W-1:0] r, i, er, ei;
                ix = mon_idx.pop_front(); r = mon_r.pop_front(); i = mon_i.pop_front();
                er = exp_r.pop_front(); ei = exp_i.pop_front();
                vectors++;
                if (ix !== j || r !== er || i !== ei) begin
                    errors++;
                    $display("FAIL midreset_bin[%0d] got idx=%0d r=%h i=%h want idx=%0d r=%h i=%h", j, ix, r, i, j, er, ei);
                end
            end
        end
    endtask

    task automatic test_extremes();
        int e; bit ok;
        clear_q();
        for (int k = 0; k < N; k++) begin
            fr_r[k] = (k % 2 == 0) ? 18'h1FFFF : 18'h20000;
            fr_i[k] = (k % 2 == 0) ? 18'h20000 : 18'h1FFFF;
        end
        drive_frame(0, e);
        intf.in_valid = 1'b0;
        collect(N, 60, ok);
        vectors++;
        if (!ok) begin errors++; $display("FAIL ext_count got %0d want %0d", mon_r.size(), N); end
        else begin
            for (int j = 0; j < N; j++) begin
                int ix; logic [W-1:0] r, i, er, ei;
                ix = mon_idx.pop_front(); r = mon_r.pop_front(); i = mon_i.pop_front();
                void'(mon_cyc.pop_front()); void'(mon_last.pop_front());
                er = exp_r.pop_front(); ei = exp_i.pop_front();
                vectors++;
                if (ix !== j || r !== er || i !== ei) begin
                    errors++;
                    $display("FAIL ext_bin[%0d] got idx=%0d r=%h i=%h want idx=%0d r=%h i=%h", j, ix, r, i, j, er, ei);
                end
            end
        end
    endtask

`ifdef REORDER_OVF_FLAG_EN
    task automatic test_ovf();
        force dut.bank_full = 2'b11;
        intf.in_valid = 1'b1; intf.in_r = 18'h00123; intf.in_i = 18'h00456;
        @(posedge clk); #1;
        intf.in_valid = 1'b0;
        release dut.bank_full;
        vectors++;
        if (intf.ovf !== 1'b1) begin errors++; $display("FAIL ovf_set got %b want 1", intf.ovf); end
        repeat (10) @(posedge clk);
        #1;
        vectors++;
        if (intf.ovf !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b want 1", intf.ovf); end
        test_reset();
        clear_q();
    endtask
`endif

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_gapped();
        test_reset_mid();
        test_extremes();
`ifdef REORDER_OVF_FLAG_EN
        test_ovf();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
